// File: rtl/fft_result_reader_if.sv
// rtl/fft_result_reader_if.sv - RAM read bus and result stream bundle for fft_result_reader
//
// Purpose: groups the RAM port-A read signals and the valid/ready result stream
//          so the reader and its environment connect through a single port.
// Signals:
//   o_rden      RAM read enable (reader -> RAM)
//   o_rdaddr_A  RAM port-A read address (reader -> RAM)
//   i_rddata_A  RAM port-A read data (RAM -> reader)
//   o_valid     result word valid (reader -> sink)
//   i_ready     sink accepts the current word (sink -> reader)
//   o_data      result word X[o_index] (reader -> sink)
//   o_index     bin number k (reader -> sink)
//   o_last      high on k == FFT_SIZE-1 (reader -> sink)
// Modports: master = the reader, slave = RAM plus sink.
interface fft_result_reader_if #(
  parameter int WORD_SIZE = 74,
  parameter int ADDR_SIZE = 4,
  parameter int IDX_SIZE  = 3
);
  logic                 o_rden;
  logic [ADDR_SIZE-1:0] o_rdaddr_A;
  logic [WORD_SIZE-1:0] i_rddata_A;
  logic                 o_valid;
  logic                 i_ready;
  logic [WORD_SIZE-1:0] o_data;
  logic [IDX_SIZE-1:0]  o_index;
  logic                 o_last;

  modport master (
    output o_rden, o_rdaddr_A, o_valid, o_data, o_index, o_last,
    input  i_rddata_A, i_ready
  );

  modport slave (
    input  o_rden, o_rdaddr_A, o_valid, o_data, o_index, o_last,
    output i_rddata_A, i_ready
  );
endinterface

// File: rtl/fft_result_reader.sv
// rtl/fft_result_reader.sv - unloads the finished FFT frame from RAM and streams it in natural order
//
// Purpose: after i_start, reads FFT_SIZE words from MEM_OFFSET.. on RAM port A and
//          presents them as bins k = 0..FFT_SIZE-1 on a valid/ready stream. A 2-entry
//          FIFO absorbs the one-cycle RAM latency and downstream backpressure.
// Ports:
//   i_CLK    system clock (the RAM runs on the opposite edge)
//   i_RST_N  asynchronous reset, active-low
//   i_start  one-cycle unload request, only honoured when idle
//   bus      fft_result_reader_if.master: RAM read bus and result stream
//   o_busy   high in every state except IDLE
//   o_done   one-cycle pulse after the last word is accepted
module fft_result_reader #(
  parameter int WORD_SIZE  = 74,
  parameter int FFT_SIZE   = 8,
  parameter int MEM_OFFSET = 8,
  parameter int ADDR_SIZE  = 4,
  parameter int IDX_SIZE   = $clog2(FFT_SIZE)
) (
  input  logic                i_CLK,
  input  logic                i_RST_N,
  input  logic                i_start,
  fft_result_reader_if.master bus,
  output logic                o_busy,
  output logic                o_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_SIZE-1:0]  LAST_IDX = IDX_SIZE'(FFT_SIZE - 1);
  localparam logic [ADDR_SIZE-1:0] BASE     = ADDR_SIZE'(MEM_OFFSET);

  logic [1:0]           state_q, state_d;
  logic [IDX_SIZE-1:0]  rd_cnt_q, rd_cnt_d;
  logic [IDX_SIZE-1:0]  out_cnt_q, out_cnt_d;
  // A read issued at one edge returns data at the next, so the registered read
  // enable is also the in-flight flag for the word arriving at the next edge.
  logic                 rden_q, rden_d;
  logic [ADDR_SIZE-1:0] rdaddr_q, rdaddr_d;

  logic [WORD_SIZE-1:0] fifo_q [2];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           fifo_cnt_q, fifo_cnt_d;

  logic                 push;
  logic                 pop;
  logic                 issue;
  logic [2:0]           occupancy;

  assign bus.o_valid    = (fifo_cnt_q != 2'd0);
  assign bus.o_data     = fifo_q[rd_ptr_q];
  assign bus.o_index    = out_cnt_q;
  assign bus.o_last     = bus.o_valid && (out_cnt_q == LAST_IDX);
  assign bus.o_rden     = rden_q;
  assign bus.o_rdaddr_A = rdaddr_q;

  assign o_busy = (state_q != S_IDLE);
  assign o_done = (state_q == S_DONE);

  assign push = rden_q;
  assign pop  = bus.o_valid && bus.i_ready;

  // Words that will be held or in flight after this edge if no new read were
  // issued; a read is only issued when that leaves room in the 2-entry FIFO.
  assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, rden_q} - {2'b00, pop};
  assign issue     = (state_q == S_READ) && (occupancy < 3'd2);

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_cnt_q;
    rden_d    = 1'b0;
    rdaddr_d  = rdaddr_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_READ;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      S_READ: begin
        if (issue && (rd_cnt_q == LAST_IDX)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && bus.o_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue) begin
      rden_d   = 1'b1;
      rdaddr_d = BASE + ADDR_SIZE'(rd_cnt_q);
      rd_cnt_d = rd_cnt_q + IDX_SIZE'(1);
    end

    if (pop) begin
      out_cnt_d = out_cnt_q + IDX_SIZE'(1);
    end
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + 2'd1;
    end else if (!push && pop) begin
      fifo_cnt_d = fifo_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q    <= S_IDLE;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      rden_q     <= 1'b0;
      rdaddr_q   <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      rden_q     <= rden_d;
      rdaddr_q   <= rdaddr_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.i_rddata_A;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule
